// File: rtl/t_ff_counter_pkg.sv
// -----------------------------------------------------------------------------
// t_ff_counter_pkg
// Shared definitions for the T flip-flop mod-N counter:
//   - direction encodings for the up_dn input (DIR_UP / DIR_DN)
//   - default WIDTH / MODULUS values
//   - params_legal(): elaboration-time legality check for WIDTH / MODULUS
// -----------------------------------------------------------------------------
package t_ff_counter_pkg;

    // Direction encodings for up_dn
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Default geometry
    localparam int DEF_WIDTH   = 32'sd4;
    localparam int DEF_MODULUS = 32'sd16;

    // WIDTH must lie in 2..16 and MODULUS in 2..2**WIDTH
    function automatic bit params_legal(input int width, input int modulus);
        bit ok;
        ok = 1'b0;
        if ((width >= 32'sd2) && (width <= 32'sd16)) begin
            ok = (modulus >= 32'sd2) && (modulus <= (32'sd1 <<< width));
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/t_ff_counter_if.sv
// -----------------------------------------------------------------------------
// t_ff_counter_if
// Control/status bundle of the T flip-flop counter.
//   master : drives en, up_dn, load, load_val; observes count, count_b, tc, wrap
//   slave  : the counter itself (opposite directions)
// Parameter WIDTH must match the counter it is connected to.
// -----------------------------------------------------------------------------
interface t_ff_counter_if
    import t_ff_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;        // count enable
    logic             up_dn;     // 1 = up, 0 = down
    logic             load;      // synchronous parallel load strobe
    logic [WIDTH-1:0] load_val;  // value to load (clamped by the counter)
    logic [WIDTH-1:0] count;     // current count
    logic [WIDTH-1:0] count_b;   // bitwise complement of count
    logic             tc;        // terminal count (combinational)
    logic             wrap;      // registered one-cycle wrap pulse

    modport master (
        output en, up_dn, load, load_val,
        input  count, count_b, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, count_b, tc, wrap
    );
endinterface

// File: rtl/t_ff_cell.sv
// -----------------------------------------------------------------------------
// t_ff_cell
// Single T flip-flop: Q toggles on a rising clk edge when T=1, otherwise holds.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset (Q=0, Qb=1)
//   T     in  toggle enable
//   Q     out stored bit
//   Qb    out complement of Q, derived from the same flop so it never skews
// -----------------------------------------------------------------------------
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic T,
    output logic Q,
    output logic Qb
);
    logic r_q;

    // Toggle storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (T) begin
            r_q <= ~r_q;
        end else begin
            r_q <= r_q;
        end
    end

    assign Q  = r_q;
    assign Qb = ~r_q;

endmodule

// File: rtl/t_ff_counter.sv
// -----------------------------------------------------------------------------
// t_ff_counter
// Synchronous mod-MODULUS up/down counter built from WIDTH T flip-flop cells.
// The next count is computed here, then turned into a per-bit toggle vector
// (count XOR next); the cells only ever see toggle enables, never a D value.
//
// Parameters:
//   WIDTH   counter width, 2..16
//   MODULUS count range 0..MODULUS-1, 2..2**WIDTH
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset (count=0, count_b=all ones, wrap=0)
//   bus   t_ff_counter_if.slave:
//         en, up_dn, load, load_val in; count, count_b, tc, wrap out
//
// Build option:
//   T_FF_COUNTER_SATURATE_EN  when defined the counter stops at MODULUS-1
//                             (up) / 0 (down) instead of wrapping; tc still
//                             flags those points and wrap stays 0.
// -----------------------------------------------------------------------------
module t_ff_counter
    import t_ff_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic          clk,
    input  logic          rst_n,
    t_ff_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 32'sd1);
    // MODULUS may equal 2**WIDTH, so the load clamp compares one bit wider
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    // A power-of-two modulus wraps for free in WIDTH-bit arithmetic
    localparam bit               POW2    = (MODULUS == (32'sd1 <<< WIDTH));

    if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
        $error("t_ff_counter: WIDTH/MODULUS out of legal range");
    end

`ifdef T_FF_COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] UP_TERM_NEXT = MAX_VAL;
    localparam logic [WIDTH-1:0] DN_TERM_NEXT = ZERO;
`else
    localparam logic [WIDTH-1:0] UP_TERM_NEXT = ZERO;
    localparam logic [WIDTH-1:0] DN_TERM_NEXT = MAX_VAL;
`endif

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_toggle;
    logic             w_up;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_over;
    logic             w_tc;
    logic             w_wrap_d;
    logic             r_wrap;

    assign w_up        = (bus.up_dn == DIR_UP);
    assign w_at_max    = (w_q == MAX_VAL);
    assign w_at_zero   = (w_q == ZERO);
    assign w_load_over = ({1'b0, bus.load_val} >= MOD_EXT);

    assign w_tc = bus.en & ~bus.load &
                  ((w_up & w_at_max) | (~w_up & w_at_zero));

    // Next-count selection: load beats enable, enable steps in up_dn direction
    always_comb begin
        w_next = w_q;
        if (bus.load) begin
            if (w_load_over) begin
                w_next = MAX_VAL;
            end else begin
                w_next = bus.load_val;
            end
        end else if (bus.en) begin
            if (w_up) begin
                if (w_at_max && !POW2) begin
                    w_next = UP_TERM_NEXT;
                end else if (w_at_max) begin
                    w_next = UP_TERM_NEXT;
                end else begin
                    w_next = w_q + ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_next = DN_TERM_NEXT;
                end else begin
                    w_next = w_q - ONE;
                end
            end
        end else begin
            w_next = w_q;
        end
    end

    // Only the bits that differ between now and next get toggled
    assign w_toggle = w_q ^ w_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        t_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .T     (w_toggle[gi]),
            .Q     (w_q[gi]),
            .Qb    (w_qb[gi])
        );
    end

`ifdef T_FF_COUNTER_SATURATE_EN
    assign w_wrap_d = 1'b0;
`else
    // tc already excludes load cycles, so a load can never raise wrap
    assign w_wrap_d = w_tc;
`endif

    // Wrap pulse: high for the one cycle following a terminal-count step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_d;
        end
    end

    assign bus.count   = w_q;
    assign bus.count_b = w_qb;
    assign bus.tc      = w_tc;
    assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_t_ff_counter.sv
// -----------------------------------------------------------------------------
// tb_t_ff_counter
// Self-checking bench for t_ff_counter (WIDTH=4, MODULUS=10): directed
// scenarios followed by randomized operations, all compared against an
// integer reference model of the counting rules.
// -----------------------------------------------------------------------------
module tb_t_ff_counter;
    import t_ff_counter_pkg::*;

    localparam int W    = 4;
    localparam int M    = 10;
    localparam int MASK = (1 << W) - 1;
`ifdef T_FF_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    t_ff_counter_if #(.WIDTH(W)) bus ();

    t_ff_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec;
    int n_err;
    int m_cnt;
    bit m_wrap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the value the count should hold after one edge
    function automatic int model_next(input int cnt, input bit en, input bit up,
                                      input bit ld, input int lv);
        int r;
        if (ld) begin
            r = (lv >= M) ? (M - 1) : lv;
        end else if (!en) begin
            r = cnt;
        end else if (up) begin
            if (SAT) r = (cnt + 1 > M - 1) ? (M - 1) : (cnt + 1);
            else     r = (cnt + 1) % M;
        end else begin
            if (SAT) r = (cnt - 1 < 0) ? 0 : (cnt - 1);
            else     r = (cnt - 1 + M) % M;
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".count"},   bus.count,   m_cnt);
        chk({tag, ".count_b"}, bus.count_b, (~m_cnt) & MASK);
        chk({tag, ".wrap"},    bus.wrap,    m_wrap);
    endtask

    // Called at posedge+1: drive, check tc, take one edge, check results
    task automatic step(input string tag, input bit en, input bit up,
                        input bit ld, input int lv);
        bit exp_tc;
        int nxt;
        bus.en       = en;
        bus.up_dn    = up;
        bus.load     = ld;
        bus.load_val = lv[W-1:0];
        #2;
        exp_tc = en && !ld && ((up && m_cnt == M - 1) || (!up && m_cnt == 0));
        chk({tag, ".tc"}, bus.tc, exp_tc);
        nxt = model_next(m_cnt, en, up, ld, lv);
        @(posedge clk);
        #1;
        m_cnt  = nxt;
        m_wrap = exp_tc && !SAT;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted mid-cycle while counting is enabled
    task automatic async_reset(input string tag);
        bus.en    = 1'b1;
        bus.up_dn = DIR_UP;
        bus.load  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        m_cnt        = 0;
        m_wrap       = 1'b0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = DIR_UP;
        bus.load     = 1'b0;
        bus.load_val = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.tc", bus.tc, 1'b0);
        rst_n = 1'b1;

        // Reset while sitting at 7 with counting enabled
        step("pre7", 1'b0, DIR_UP, 1'b1, 6);
        step("to7",  1'b1, DIR_UP, 1'b0, 0);
        async_reset("rst7");
        step("post_rst", 1'b1, DIR_UP, 1'b0, 0);

        // Up wrap: 0..9,0 with tc at 9 and a single wrap pulse
        step("ld0", 1'b0, DIR_UP, 1'b1, 0);
        for (int i = 0; i < M; i++) step("up", 1'b1, DIR_UP, 1'b0, 0);
        step("up_after", 1'b1, DIR_UP, 1'b0, 0);
        step("idle", 1'b0, DIR_UP, 1'b0, 0);

        // Down wrap from 0
        step("ld0d", 1'b0, DIR_DN, 1'b1, 0);
        step("dn_wrap", 1'b1, DIR_DN, 1'b0, 0);
        step("dn_next", 1'b1, DIR_DN, 1'b0, 0);

        // Load priority and clamp; load at a terminal value raises no wrap
        step("ld12", 1'b1, DIR_UP, 1'b1, 12);
        step("ld9_term", 1'b1, DIR_UP, 1'b1, 9);
        step("ld15", 1'b1, DIR_DN, 1'b1, 15);
        step("ld5", 1'b1, DIR_DN, 1'b1, 5);

        // Hold at 4 then alternating direction 5,4,5
        step("ld4", 1'b0, DIR_UP, 1'b1, 4);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
        step("alt_up", 1'b1, DIR_UP, 1'b0, 0);
        step("alt_dn", 1'b1, DIR_DN, 1'b0, 0);
        step("alt_up2", 1'b1, DIR_UP, 1'b0, 0);

        // Counting up from 8 across the top (saturates or wraps by build)
        step("ld8", 1'b0, DIR_UP, 1'b1, 8);
        for (int i = 0; i < 4; i++) step("top", 1'b1, DIR_UP, 1'b0, 0);

        // Randomized operations with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, MASK)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
